header_enc: RTL and testbench

//  MoldUDP64 transmit-side header encoder; the inverse of the receive-side header decoder.

---
 rtl/header_enc.sv | 145 ++++++++++++++
 tb/tb_header_enc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/header_enc.sv
// Transmit-side header encoder: serialises a 20-byte header (session id, sequence number,
// message count) as three 64-bit beats and owns the sequence counter.
module header_enc #(
  parameter int SID_W  = 80,
  parameter int SEQ_W  = 64,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seq_ld_v_i,
  input  logic [SEQ_W-1:0]  seq_ld_i,
  input  logic              start_v_i,
  output logic              start_ready_o,
  input  logic [SID_W-1:0]  sid_i,
  input  logic [CNT_W-1:0]  msg_cnt_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              h0_v_o,
  output logic              h1_v_o,
  output logic              h2_v_o,
  output logic [SEQ_W-1:0]  seq_num_o
);

  typedef enum logic [1:0] {S_IDLE, S_H0, S_H1, S_H2} state_e;

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [SEQ_W-1:0]   seq_hdr_q, seq_hdr_d;
  logic [SID_W-1:0]   sid_q, sid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [2:0]         hv_q, hv_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [KEEP_W-1:0]  keep_q, keep_d;
  logic               xfer;
  logic               accept;

  // An all-ones count marks end of session and must not move the counter.
  function automatic logic [SEQ_W-1:0] seq_advance(input logic [SEQ_W-1:0] seq,
                                                   input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) return seq;
    return seq + SEQ_W'(cnt);
  endfunction

  always_comb begin
    start_ready_o = ((state_q == S_IDLE) & ~seq_ld_v_i) | ((state_q == S_H2) & ready_i);
    accept        = start_v_i & start_ready_o;
    xfer          = (state_q != S_IDLE) & ready_i;
  end

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    seq_hdr_d = seq_hdr_q;
    sid_d     = sid_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    hv_d      = 3'b000;
    data_d    = '0;
    keep_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (seq_ld_v_i)  seq_d   = seq_ld_i;
        else if (accept) state_d = S_H0;
      end
      S_H0: if (xfer) state_d = S_H1;
      S_H1: if (xfer) state_d = S_H2;
      S_H2: begin
        if (xfer) begin
          seq_d   = seq_advance(seq_q, cnt_q);
          state_d = accept ? S_H0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // seq_d already carries a same-cycle h2 increment, so back-to-back headers see it.
    if (accept) begin
      sid_d     = sid_i;
      cnt_d     = msg_cnt_i;
      seq_hdr_d = seq_d;
    end

    // Outputs are built from next-state values so they register alongside the state.
    case (state_d)
      S_H0: begin
        valid_d = 1'b1;
        hv_d    = 3'b001;
        data_d  = sid_d[SID_W-1 -: DATA_W];
        keep_d  = '1;
      end
      S_H1: begin
        valid_d = 1'b1;
        hv_d    = 3'b010;
        data_d  = {seq_hdr_d[SEQ_W-1:16], sid_d[15:0]};
        keep_d  = '1;
      end
      S_H2: begin
        valid_d = 1'b1;
        hv_d    = 3'b100;
        data_d  = {{(DATA_W-CNT_W-16){1'b0}}, cnt_d, seq_hdr_d[15:0]};
        keep_d  = KEEP_W'(8'h0F);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      seq_q   <= SEQ_W'(1);
      valid_q <= 1'b0;
      hv_q    <= 3'b000;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      hv_q    <= hv_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  always_ff @(posedge clk) begin
    seq_hdr_q <= seq_hdr_d;
    sid_q     <= sid_d;
    cnt_q     <= cnt_d;
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign keep_o    = keep_q;
  assign h0_v_o    = hv_q[0];
  assign h1_v_o    = hv_q[1];
  assign h2_v_o    = hv_q[2];
  assign seq_num_o = seq_q;

endmodule

// File: tb/tb_header_enc.sv
// Scoreboard bench for header_enc: a driver pushes each accepted header's expected beats,
// a monitor compares every presented beat against the queue head.
module tb_header_enc;

  logic         clk = 1'b0;
  logic         reset;
  logic         seq_ld_v_i;
  logic [63:0]  seq_ld_i;
  logic         start_v_i;
  logic         start_ready_o;
  logic [79:0]  sid_i;
  logic [15:0]  msg_cnt_i;
  logic         ready_i;
  logic         valid_o;
  logic [63:0]  data_o;
  logic [7:0]   keep_o;
  logic         h0_v_o, h1_v_o, h2_v_o;
  logic [63:0]  seq_num_o;

  header_enc dut (
    .clk(clk), .reset(reset), .seq_ld_v_i(seq_ld_v_i), .seq_ld_i(seq_ld_i),
    .start_v_i(start_v_i), .start_ready_o(start_ready_o), .sid_i(sid_i),
    .msg_cnt_i(msg_cnt_i), .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o),
    .keep_o(keep_o), .h0_v_o(h0_v_o), .h1_v_o(h1_v_o), .h2_v_o(h2_v_o),
    .seq_num_o(seq_num_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [2:0]  oh;    // {h2,h1,h0}
    logic [63:0] seq;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] model_seq;
  bit          mon_en = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: manual
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Header layout from the beat rules: h0 = sid high 64 bits; h1 = seq[63:16] over sid[15:0];
  // h2 = count over seq[15:0] in the low 4 bytes.
  task automatic push_header(input logic [79:0] sid, input logic [15:0] cnt);
    logic [63:0] hs;
    hs = model_seq;
    sb.push_back('{data: sid[79:16], keep: 8'hFF, oh: 3'b001, seq: hs});
    sb.push_back('{data: {hs[63:16], sid[15:0]}, keep: 8'hFF, oh: 3'b010, seq: hs});
    sb.push_back('{data: {32'h0, cnt, hs[15:0]}, keep: 8'h0F, oh: 3'b100, seq: hs});
    if (cnt != 16'hFFFF) model_seq = hs + 64'(cnt);
  endtask

  task automatic do_cycle(output bit acc);
    logic [79:0] s;
    logic [15:0] c;
    @(negedge clk);
    acc = start_v_i && start_ready_o && !reset;
    s = sid_i;
    c = msg_cnt_i;
    @(posedge clk);
    #1;
    if (acc) push_header(s, c);
  endtask

  task automatic send_hdr(input logic [79:0] sid, input logic [15:0] cnt, input bit ldpulse);
    bit acc;
    acc = 0;
    start_v_i = 1'b1;
    sid_i = sid;
    msg_cnt_i = cnt;
    for (int i = 0; i < 100 && !acc; i++) do_cycle(acc);
    if (!acc) check("accept_timeout", 192'(acc), 192'(1));
    start_v_i = 1'b0;
    if (ldpulse) begin
      // Two cycles after an accept the header is always still in flight.
      seq_ld_v_i = 1'b1;
      seq_ld_i = {$urandom(), $urandom()};
      do_cycle(acc);
      do_cycle(acc);
      seq_ld_v_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit acc;
    start_v_i = 1'b0;
    for (int i = 0; i < 300 && sb.size() != 0; i++) do_cycle(acc);
    check("drain_timeout", 192'(sb.size() == 0), 192'(1));
    do_cycle(acc);
  endtask

  task automatic load_seq(input logic [63:0] v);
    bit acc;
    wait_idle();
    seq_ld_v_i = 1'b1;
    seq_ld_i = v;
    start_v_i = 1'b1;
    sid_i = {$urandom(), $urandom(), 16'($urandom())};
    msg_cnt_i = 16'd1;
    do_cycle(acc);
    check("ld_priority", 192'(acc), 192'(0));
    seq_ld_v_i = 1'b0;
    start_v_i = 1'b0;
    model_seq = v;
    check("ld_value", 192'(seq_num_o), 192'(v));
  endtask

  function automatic logic [15:0] pick_cnt();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'($urandom());
      default: return 16'($urandom_range(1, 10));
    endcase
  endfunction

  // Monitor: with nothing expected the outputs must be idle; otherwise the head beat must show.
  initial begin
    beat_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        check("idle_out", 192'({valid_o, h2_v_o, h1_v_o, h0_v_o, keep_o, data_o}), 192'(0));
      end else begin
        e = sb[0];
        check("beat", 192'({valid_o, h2_v_o, h1_v_o, h0_v_o, keep_o, data_o, seq_num_o}),
              192'({1'b1, e.oh, e.keep, e.data, e.seq}));
        if (ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) ready_i = 1'b1;
      else if (rdy_mode == 1) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bit acc;
    reset = 1'b1;
    seq_ld_v_i = 1'b0;
    seq_ld_i = '0;
    start_v_i = 1'b0;
    sid_i = '0;
    msg_cnt_i = '0;
    ready_i = 1'b1;
    model_seq = 64'd1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", 192'({valid_o, h2_v_o, h1_v_o, h0_v_o, keep_o, data_o}), 192'(0));
    check("rst_start_ready", 192'(start_ready_o), 192'(1));
    check("rst_seq", 192'(seq_num_o), 192'(1));
    mon_en = 1;

    // Basic header
    send_hdr(80'h4142434445464748494A, 16'd3, 0);
    wait_idle();
    check("t1_seq", 192'(seq_num_o), 192'(4));

    // Stall during h1
    rdy_mode = 2;
    ready_i = 1'b1;
    send_hdr(80'h0102030405060708090A, 16'd7, 0);
    do_cycle(acc);
    ready_i = 1'b0;
    repeat (5) do_cycle(acc);
    check("t2_seq_held", 192'(seq_num_o), 192'(4));
    ready_i = 1'b1;
    rdy_mode = 0;
    wait_idle();
    check("t2_seq", 192'(seq_num_o), 192'(11));

    // Back-to-back from seq 1
    load_seq(64'd1);
    send_hdr(80'hAAAA_BBBB_CCCC_DDDD_EEEE, 16'd2, 0);
    send_hdr(80'h1111_2222_3333_4444_5555, 16'd0, 0);
    wait_idle();
    check("t3_seq", 192'(seq_num_o), 192'(3));

    // Wrap
    load_seq(64'hFFFF_FFFF_FFFF_FFFF);
    send_hdr(80'h5A5A_5A5A_5A5A_5A5A_5A5A, 16'd2, 0);
    wait_idle();
    check("t4_wrap", 192'(seq_num_o), 192'(1));

    // End of session plus ignored load in flight
    send_hdr(80'h0F0F_0F0F_0F0F_0F0F_0F0F, 16'hFFFF, 1);
    wait_idle();
    check("t5_eos", 192'(seq_num_o), 192'(1));

    // Reset mid-header with ready low
    load_seq(64'd100);
    rdy_mode = 2;
    ready_i = 1'b1;
    send_hdr(80'h1234_5678_9ABC_DEF0_1357, 16'd5, 0);
    do_cycle(acc);
    ready_i = 1'b0;
    repeat (2) do_cycle(acc);
    reset = 1'b1;
    do_cycle(acc);
    reset = 1'b0;
    sb.delete();
    model_seq = 64'd1;
    check("t6_valid", 192'({valid_o, h2_v_o, h1_v_o, h0_v_o}), 192'(0));
    check("t6_start_ready", 192'(start_ready_o), 192'(1));
    check("t6_seq", 192'(seq_num_o), 192'(1));
    ready_i = 1'b1;
    repeat (3) do_cycle(acc);
    rdy_mode = 0;

    // Randomized traffic
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) load_seq({$urandom(), $urandom()});
        else load_seq(64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)));
      end else begin
        send_hdr({$urandom(), $urandom(), 16'($urandom())}, pick_cnt(),
                 ($urandom_range(0, 3) == 0));
      end
    end
    wait_idle();
    check("final_seq", 192'(seq_num_o), 192'(model_seq));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
